scv_bootrom: RTL and testbench
==============================

// Module: scv_bootrom
// PURPOSE
//  Synthesizable, parametrised boot ROM for the uPD7800 core; replaces the $readmemh behavioural ROM.
//  Image is downloaded at power-up through a byte-write port (host/loader side).
//  CPU reads are sampled on the CP2_POSEDGE phase strobe. CPU_HOLD keeps the CPU in reset until a complete image is loaded.
// PARAMETERS
//  AW        12      address width; depth = 1<<AW words
//  DW        8       data width
//  FILL      8'hFF   value driven on DB when ROM not READY (replicated to DW)
//  IMG_LEN   4096    words required before DL_DONE is accepted as complete (1..1<<AW)
// PORTS
//  CLK          in   1      system clock
//  RESETB       in   1      async active-low reset
//  CP2_POSEDGE  in   1      CPU phase strobe, one CLK wide; CPU read sample point
//  A            in   AW     CPU address (external decode already applied)
//  nCS          in   1      CPU chip select, active low
//  DB           out  DW     read data
//  DB_OE        out  1      DB valid/drive enable
//  DL_START     in   1      pulse: begin image download
//  DL_WR        in   1      download write strobe (one word per CLK max)
//  DL_ADDR      in   AW     download word address
//  DL_DATA      in   DW     download word
//  DL_DONE      in   1      pulse: host finished download
//  DL_COUNT     out  AW+1   distinct-order write count since DL_START (saturates at 1<<AW)
//  READY        out  1      image valid, CPU reads enabled
//  ERR          out  1      DL_DONE seen with DL_COUNT < IMG_LEN
//  CPU_HOLD     out  1      = ~READY; drives CPU RESETB low externally
// BEHAVIOUR
//  Reset (RESETB=0, async): state=EMPTY, DB=FILL, DB_OE=0, DL_COUNT=0, READY=0, ERR=0, CPU_HOLD=1. RAM contents not cleared.
//  FSM: EMPTY -DL_START-> LOAD; LOAD -DL_DONE & count>=IMG_LEN-> READY; LOAD -DL_DONE & count<IMG_LEN-> FAIL (ERR=1).
//   READY/FAIL -DL_START-> LOAD (READY drops, ERR clears, DL_COUNT=0 same edge). DL_START in LOAD restarts count.
//  DL_WR honoured only in LOAD; written to RAM same edge; DL_COUNT+1 per DL_WR (rewrites counted; saturate, no wrap).
//  DL_WR outside LOAD ignored. DL_START and DL_WR same cycle: START wins, write dropped.
//  DL_DONE and DL_WR same cycle: write accepted and counted before completeness check.
//  CPU read: edge with CP2_POSEDGE & ~nCS samples A; RAM registered, DB = mem[A] valid the next CLK (latency 1), held until next sample.
//  Not READY at sample: DB=FILL. DB_OE=1 from the cycle after sample while nCS low; DB_OE=0 the cycle after nCS rises.
//  Reset mid-download: back to EMPTY; partial image invalid (CPU_HOLD=1) until a full new download.
//  No A range check needed (A is AW bits; full depth addressable).
// CONFIGURATION
//  BOOTROM_CHECKSUM_EN defined: extra outputs CKSUM[15:0] (mod-2^16 sum of DL_DATA over accepted writes, cleared at DL_START)
//   and parameter CKSUM_EXP (16'h0000); LOAD->READY additionally requires CKSUM==CKSUM_EXP, else FAIL with ERR=1.
//  Undefined: no CKSUM port/parameter; completeness judged on DL_COUNT only.
// STRUCTURE
//  Package bootrom_pkg: state enum {EMPTY,LOAD,READY,FAIL}, default AW/DW localparams.
//  Sub-module bootrom_ram: simple dual-port sync RAM (1 write port, 1 registered read port), inferable as block RAM.
//  Top holds FSM, counter, read-sample logic, DB/DB_OE registers, optional checksum.
// TESTING
//  1 Reset, no download, CP2 reads with nCS=0 -> DB=8'hFF, DB_OE=1 next cycle, CPU_HOLD=1.
//  2 DL_START, 4096 writes mem[i]=i[7:0], DL_DONE -> READY=1, CPU_HOLD=0; read A=12'h0A5 -> DB=8'hA5 one CLK after CP2.
//  3 DL_START, 100 writes, DL_DONE -> ERR=1, READY=0, DL_COUNT=100; reads return 8'hFF.
//  4 RESETB low mid-download (count 2000) -> EMPTY, DL_COUNT=0, CPU_HOLD=1 asynchronously.
//  5 DL_START+DL_WR same cycle -> write dropped, DL_COUNT=0; DL_DONE+last DL_WR -> count 4096, READY=1.
//  6 BOOTROM_CHECKSUM_EN, CKSUM_EXP=16'h0000, image sum 16'h7F80 -> FAIL, ERR=1; matching image -> READY.

Source files
------------

// File: rtl/bootrom_pkg.sv
// Shared types and defaults for the uPD7800 boot ROM.
// Optional checksum gate: BOOTROM_CHECKSUM_EN.
package bootrom_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 8;
  localparam int CKW    = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    FAIL  = 2'd3
  } state_t;

endpackage

// File: rtl/scv_bootrom_if.sv
// CPU read bus and loader download bus of the boot ROM.
// CKSUM is present only with BOOTROM_CHECKSUM_EN.
interface scv_bootrom_if
  import bootrom_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          CP2_POSEDGE;
  logic [AW-1:0] A;
  logic          nCS;
  logic [DW-1:0] DB;
  logic          DB_OE;

  logic          DL_START;
  logic          DL_WR;
  logic [AW-1:0] DL_ADDR;
  logic [DW-1:0] DL_DATA;
  logic          DL_DONE;
  logic [AW:0]   DL_COUNT;

  logic          READY;
  logic          ERR;
  logic          CPU_HOLD;
`ifdef BOOTROM_CHECKSUM_EN
  logic [CKW-1:0] CKSUM;
`endif

  modport master (
    output CP2_POSEDGE, A, nCS,
    output DL_START, DL_WR, DL_ADDR,
    output DL_DATA, DL_DONE,
`ifdef BOOTROM_CHECKSUM_EN
    input  CKSUM,
`endif
    input  DB, DB_OE, DL_COUNT,
    input  READY, ERR, CPU_HOLD
  );

  modport slave (
    input  CP2_POSEDGE, A, nCS,
    input  DL_START, DL_WR, DL_ADDR,
    input  DL_DATA, DL_DONE,
`ifdef BOOTROM_CHECKSUM_EN
    output CKSUM,
`endif
    output DB, DB_OE, DL_COUNT,
    output READY, ERR, CPU_HOLD
  );

endinterface

// File: rtl/bootrom_ram.sv
// Simple dual-port sync RAM: one write port, one
// enable-gated registered read port (block RAM style).
module bootrom_ram #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [1<<AW];
  logic [DW-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  // No reset: contents and read latch survive RESETB
  always_ff @(posedge i_clk) begin
    if (i_re)
      r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/scv_bootrom.sv
// Downloadable boot ROM for the uPD7800 core; holds the CPU
// until a full image is loaded. Option: BOOTROM_CHECKSUM_EN.
module scv_bootrom
  import bootrom_pkg::*;
#(
  parameter int         AW      = AW_DEF,
  parameter int         DW      = DW_DEF,
  parameter logic [7:0] FILL    = 8'hFF,
  parameter int         IMG_LEN = 4096
`ifdef BOOTROM_CHECKSUM_EN
  ,
  parameter logic [CKW-1:0] CKSUM_EXP = 16'h0000
`endif
) (
  input  logic         CLK,
  input  logic         RESETB,
  scv_bootrom_if.slave bus
);

  localparam int NREP = (DW + 7) / 8;
  localparam logic [NREP*8-1:0] LP_FILLX =
    {NREP{FILL}};
  localparam logic [DW-1:0] LP_FILL =
    LP_FILLX[DW-1:0];
  localparam logic [AW:0] LP_DEPTH =
    {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] LP_IMG =
    (AW+1)'(IMG_LEN);
  localparam logic [AW:0] LP_ONE =
    (AW+1)'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW:0]   r_cnt;
  logic [AW:0]   w_cnt_nxt;
  logic          w_wr_acc;
  logic          w_rd_smp;
  logic          w_img_ok;
  logic          w_ready;
  logic          r_fill;
  logic          r_oe;
  logic [DW-1:0] w_q;

  assign w_ready  = (r_state == READY);
  assign w_rd_smp = bus.CP2_POSEDGE & ~bus.nCS;

  // START pre-empts a same-cycle write
  assign w_wr_acc = (r_state == LOAD) &
                    bus.DL_WR & ~bus.DL_START;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (bus.DL_START)
      w_cnt_nxt = '0;
    else if (w_wr_acc && r_cnt != LP_DEPTH)
      w_cnt_nxt = r_cnt + LP_ONE;
  end

`ifdef BOOTROM_CHECKSUM_EN
  logic [CKW-1:0] r_ck;
  logic [CKW-1:0] w_ck_nxt;

  always_comb begin
    w_ck_nxt = r_ck;
    if (bus.DL_START)
      w_ck_nxt = '0;
    else if (w_wr_acc)
      w_ck_nxt = r_ck + CKW'(bus.DL_DATA);
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB)
      r_ck <= '0;
    else
      r_ck <= w_ck_nxt;
  end

  assign bus.CKSUM = r_ck;
  assign w_img_ok  = (w_cnt_nxt >= LP_IMG) &&
                     (w_ck_nxt == CKSUM_EXP);
`else
  assign w_img_ok = (w_cnt_nxt >= LP_IMG);
`endif

  // Completeness uses the count including a same-cycle write
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY: begin
        if (bus.DL_START)
          w_state_nxt = LOAD;
      end
      LOAD: begin
        if (bus.DL_START)
          w_state_nxt = LOAD;
        else if (bus.DL_DONE)
          w_state_nxt = w_img_ok ? READY : FAIL;
      end
      READY, FAIL: begin
        if (bus.DL_START)
          w_state_nxt = LOAD;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_state <= EMPTY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_fill <= 1'b1;
      r_oe   <= 1'b0;
    end else if (w_rd_smp) begin
      r_fill <= ~w_ready;
      r_oe   <= 1'b1;
    end else if (bus.nCS) begin
      r_oe   <= 1'b0;
    end
  end

  bootrom_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_wr_acc),
    .i_waddr (bus.DL_ADDR),
    .i_wdata (bus.DL_DATA),
    .i_re    (w_rd_smp),
    .i_raddr (bus.A),
    .o_rdata (w_q)
  );

  assign bus.DB       = r_fill ? LP_FILL : w_q;
  assign bus.DB_OE    = r_oe;
  assign bus.DL_COUNT = r_cnt;
  assign bus.READY    = w_ready;
  assign bus.ERR      = (r_state == FAIL);
  assign bus.CPU_HOLD = ~w_ready;

endmodule

// File: tb/tb_scv_bootrom.sv
// Directed/randomized bench for scv_bootrom against an
// image-level model (array image + write count + sum).
module tb_scv_bootrom;
  import bootrom_pkg::*;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 4096;
  localparam int IMG   = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scv_bootrom_if #(.AW(AW), .DW(DW)) bus ();

  scv_bootrom #(
    .AW      (AW),
    .DW      (DW),
    .FILL    (8'hFF),
    .IMG_LEN (IMG)
  ) dut (
    .CLK    (clk),
    .RESETB (rst_n),
    .bus    (bus)
  );

  logic [7:0]  mem_m [DEPTH];
  int          cnt_m;
  int unsigned ck_m;
  bit          ready_m;
  bit          err_m;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic status(input string tag);
    chk({tag, ".ready"}, 32'(bus.READY), 32'(ready_m));
    chk({tag, ".err"}, 32'(bus.ERR), 32'(err_m));
    chk({tag, ".hold"}, 32'(bus.CPU_HOLD),
        32'(!ready_m));
    chk({tag, ".count"}, 32'(bus.DL_COUNT),
        32'(cnt_m));
  endtask

  task automatic start();
    bus.DL_START = 1'b1;
    tick();
    bus.DL_START = 1'b0;
    cnt_m   = 0;
    ck_m    = 0;
    ready_m = 1'b0;
    err_m   = 1'b0;
  endtask

  task automatic model_wr(input int a, input int d);
    mem_m[a] = 8'(d);
    cnt_m    = (cnt_m < DEPTH) ? cnt_m + 1 : DEPTH;
    ck_m     = (ck_m + 32'(d & 255)) & 32'hFFFF;
  endtask

  task automatic wr(input int a, input int d);
    bus.DL_WR   = 1'b1;
    bus.DL_ADDR = 12'(a);
    bus.DL_DATA = 8'(d);
    tick();
    bus.DL_WR = 1'b0;
    model_wr(a, d);
  endtask

  task automatic done(input bit w, input int a,
                      input int d);
    bus.DL_DONE = 1'b1;
    bus.DL_WR   = w;
    bus.DL_ADDR = 12'(a);
    bus.DL_DATA = 8'(d);
    tick();
    bus.DL_DONE = 1'b0;
    bus.DL_WR   = 1'b0;
    if (w) model_wr(a, d);
    ready_m = (cnt_m >= IMG);
`ifdef BOOTROM_CHECKSUM_EN
    ready_m = ready_m && (ck_m == 0);
`endif
    err_m = !ready_m;
  endtask

  task automatic rd(input string tag, input int a);
    logic [7:0] e;
    e = ready_m ? mem_m[a] : 8'hFF;
    bus.CP2_POSEDGE = 1'b1;
    bus.nCS         = 1'b0;
    bus.A           = 12'(a);
    tick();
    bus.CP2_POSEDGE = 1'b0;
    bus.A           = 12'($urandom);
    chk({tag, ".db"}, 32'(bus.DB), 32'(e));
    chk({tag, ".oe"}, 32'(bus.DB_OE), 32'd1);
    tick();
    chk({tag, ".hold_db"}, 32'(bus.DB), 32'(e));
    bus.nCS = 1'b1;
    tick();
    chk({tag, ".oe_off"}, 32'(bus.DB_OE), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int a;
    int d;
    bus.CP2_POSEDGE = 1'b0;
    bus.A           = '0;
    bus.nCS         = 1'b1;
    bus.DL_START    = 1'b0;
    bus.DL_WR       = 1'b0;
    bus.DL_ADDR     = '0;
    bus.DL_DATA     = '0;
    bus.DL_DONE     = 1'b0;
    cnt_m   = 0;
    ck_m    = 0;
    ready_m = 1'b0;
    err_m   = 1'b0;

    // reset state and fill reads
    repeat (2) tick();
    status("rst");
    chk("rst.db", 32'(bus.DB), 32'hFF);
    chk("rst.oe", 32'(bus.DB_OE), 32'd0);
    rst_n = 1'b1;
    tick();
    rd("empty_rd", int'($urandom_range(0, 4095)));
    status("empty");

    // full image with saturating rewrites
    start();
    for (int i = 0; i < DEPTH; i++)
      wr(i, i & 255);
    for (int i = 0; i < 10; i++)
      wr(int'($urandom_range(0, 4095)),
         int'($urandom_range(0, 255)));
    status("sat");
    done(1'b0, 0, 0);
    status("full");
    rd("rd_a5", 12'h0A5);
    for (int i = 0; i < 8; i++)
      rd("rd_rand", int'($urandom_range(0, 4095)));

    // short image
    start();
    status("restart");
    for (int i = 0; i < 100; i++)
      wr(int'($urandom_range(0, 4095)),
         int'($urandom_range(0, 255)));
    done(1'b0, 0, 0);
    status("short");
    rd("short_rd", 12'h0A5);

    // async reset mid-download
    start();
    for (int i = 0; i < 2000; i++)
      wr(i, (i ^ 8'h33) & 255);
    status("mid");
    #2;
    rst_n = 1'b0;
    #1;
    cnt_m   = 0;
    ready_m = 1'b0;
    err_m   = 1'b0;
    status("arst");
    chk("arst.oe", 32'(bus.DB_OE), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.DL_WR   = 1'b1;
    bus.DL_ADDR = 12'd7;
    bus.DL_DATA = 8'hEE;
    tick();
    bus.DL_WR = 1'b0;
    status("ign_wr");
    rd("post_rst", int'($urandom_range(0, 4095)));

    // START beats WR; DONE with last WR
    bus.DL_START = 1'b1;
    bus.DL_WR    = 1'b1;
    bus.DL_ADDR  = 12'd7;
    bus.DL_DATA  = 8'h5A;
    tick();
    bus.DL_START = 1'b0;
    bus.DL_WR    = 1'b0;
    cnt_m   = 0;
    ck_m    = 0;
    ready_m = 1'b0;
    err_m   = 1'b0;
    status("st_wr");
    for (int i = 0; i < DEPTH - 1; i++) begin
      a = (i == 7) ? 0 : i;
      wr(a, int'($urandom_range(0, 255)));
    end
    chk("pre_done", 32'(bus.DL_COUNT),
        32'(DEPTH - 1));
    done(1'b1, DEPTH - 1,
         int'($urandom_range(0, 255)));
    status("done_wr");
    rd("keep7", 7);
    for (int i = 0; i < 6; i++)
      rd("rd5", int'($urandom_range(0, 4095)));

`ifdef BOOTROM_CHECKSUM_EN
    // paired bytes sum to 256 each: total 0 mod 2^16
    start();
    for (int i = 0; i < DEPTH; i += 2) begin
      d = int'($urandom_range(1, 255));
      wr(i, d);
      wr(i + 1, 256 - d);
    end
    chk("cksum", 32'(bus.CKSUM), ck_m);
    done(1'b0, 0, 0);
    status("ck_ok");
    rd("ck_rd", int'($urandom_range(0, 4095)));
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
